// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_pkg                                                         |
// | Shared FSM encoding, opcodes, error codes and checksum helper.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_cmd_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_DHI  = 3'd2;
   localparam logic [2:0] ST_DLO  = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;

   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_START = 4'h2;
   localparam logic [3:0] OP_STOP  = 4'h3;

   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OPCODE  = 2'd3;

   function automatic logic [7:0] calc_csum(input logic [7:0] cmd,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
      return cmd ^ dhi ^ dlo;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_timer                                                       |
// | Inter-byte gap counter; flags expiry on its TIMEOUT_CYC-th step.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_cmd_timer #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Fires in the cycle whose increment would make the count reach TIMEOUT_CYC.
   assign expired = enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_ctrl                                                        |
// | Decodes SYNC/CMD/DHI/DLO/CSUM byte frames into register writes and   |
// | correlator start/stop pulses, with checksum and timeout errors.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        reg_wr_en,
   output logic [3:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        corr_start,
   output logic        corr_stop,
   output logic        busy,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  err_count
);

   logic [2:0] r_state;
   logic [7:0] r_cmd;
   logic [7:0] r_dhi;
   logic [7:0] r_dlo;

   logic       w_expired;
   logic       w_tmr_clear;
   logic       w_tmr_enable;
   logic       w_frame_end;
   logic       w_csum_ok;
   logic       w_op_ok;
   logic [3:0] w_op;

   assign busy         = (r_state != ST_IDLE);
   assign w_tmr_enable = busy && !rx_valid;
   assign w_tmr_clear  = rx_valid || !busy || w_expired;

   assign w_op        = r_cmd[7:4];
   assign w_frame_end = (r_state == ST_CSUM) && rx_valid;
   assign w_csum_ok   = (rx_byte == calc_csum(r_cmd, r_dhi, r_dlo));
   assign w_op_ok     = (w_op == OP_WRITE) || (w_op == OP_START) || (w_op == OP_STOP);

   uart_cmd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_tmr_clear),
      .enable  (w_tmr_enable),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cmd      <= '0;
         r_dhi      <= '0;
         r_dlo      <= '0;
         reg_wr_en  <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         corr_start <= 1'b0;
         corr_stop  <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= '0;
         err_count  <= '0;
      end else begin
         reg_wr_en  <= 1'b0;
         corr_start <= 1'b0;
         corr_stop  <= 1'b0;
         frame_err  <= 1'b0;

         if (w_expired) begin
            r_state   <= ST_IDLE;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
         end else if (rx_valid) begin
            case (r_state)
               ST_IDLE: if (rx_byte == SYNC_BYTE) r_state <= ST_CMD;
               ST_CMD: begin
                  r_cmd   <= rx_byte;
                  r_state <= ST_DHI;
               end
               ST_DHI: begin
                  r_dhi   <= rx_byte;
                  r_state <= ST_DLO;
               end
               ST_DLO: begin
                  r_dlo   <= rx_byte;
                  r_state <= ST_CSUM;
               end
               default: r_state <= ST_IDLE;
            endcase
         end

         // Checksum failure takes precedence over an unknown opcode.
         if (w_frame_end) begin
            if (!w_csum_ok || !w_op_ok) begin
               frame_err <= 1'b1;
               err_code  <= !w_csum_ok ? ERR_CSUM : ERR_OPCODE;
               if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            end else begin
               case (w_op)
                  OP_WRITE: begin
                     reg_wr_en <= 1'b1;
                     reg_addr  <= r_cmd[3:0];
                     reg_wdata <= {r_dhi, r_dlo};
                  end
                  OP_START: corr_start <= 1'b1;
                  default:  corr_stop  <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_cmd_ctrl                                                     |
// | Directed self-checking bench for uart_cmd_ctrl (TIMEOUT_CYC = 16).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        reg_wr_en;
   logic [3:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        corr_start;
   logic        corr_stop;
   logic        busy;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  err_count;

   int vectors;
   int fails;

   uart_cmd_ctrl #(
      .TIMEOUT_CYC (16),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .reg_wr_en  (reg_wr_en),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .corr_start (corr_start),
      .corr_stop  (corr_stop),
      .busy       (busy),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; presents the byte for exactly one rising edge.
   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] s);
      send(8'hA5);
      send(c);
      send(h);
      send(l);
      send(s);
   endtask

   initial begin
      vectors  = 0;
      fails    = 0;
      rst_n    = 1'b0;
      rx_byte  = 8'h00;
      rx_valid = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_wr_en", reg_wr_en, 0);
      check("rst_addr", reg_addr, 0);
      check("rst_wdata", reg_wdata, 0);
      check("rst_flags", {corr_start, corr_stop, frame_err}, 0);
      check("rst_err_code", err_code, 0);
      check("rst_err_count", err_count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Register write
      send_frame(8'h13, 8'h12, 8'h34, 8'h35);
      check("wr_en", reg_wr_en, 1);
      check("wr_addr", reg_addr, 4'h3);
      check("wr_data", reg_wdata, 16'h1234);
      check("wr_no_err", frame_err, 0);
      check("wr_err_count", err_count, 0);
      @(negedge clk);
      check("wr_pulse_end", reg_wr_en, 0);
      check("wr_data_held", reg_wdata, 16'h1234);

      // Correlator start / stop
      send_frame(8'h20, 8'h00, 8'h00, 8'h20);
      check("start_pulse", corr_start, 1);
      check("start_no_wr", reg_wr_en, 0);
      @(negedge clk);
      check("start_end", corr_start, 0);
      send_frame(8'h30, 8'h00, 8'h00, 8'h30);
      check("stop_pulse", {corr_stop, corr_start, reg_wr_en}, 3'b100);

      // Checksum error, then a good frame
      send_frame(8'h13, 8'h12, 8'h34, 8'h00);
      check("csum_err", frame_err, 1);
      check("csum_code", err_code, 1);
      check("csum_no_wr", reg_wr_en, 0);
      check("csum_count", err_count, 1);
      send_frame(8'h17, 8'hAB, 8'hCD, 8'h71);
      check("after_err_wr", {reg_wr_en, reg_addr, reg_wdata}, {1'b1, 4'h7, 16'hABCD});
      check("after_err_no_err", frame_err, 0);

      // Bad opcode
      send_frame(8'h53, 8'h00, 8'h00, 8'h53);
      check("op_err", frame_err, 1);
      check("op_code", err_code, 3);
      check("op_no_out", {reg_wr_en, corr_start, corr_stop}, 0);
      check("op_count", err_count, 2);

      // SYNC value inside a frame is ordinary data
      send_frame(8'h15, 8'hA5, 8'h00, 8'hB0);
      check("sync_as_data", {reg_wr_en, reg_addr, reg_wdata}, {1'b1, 4'h5, 16'hA500});

      // Non-sync bytes in IDLE are dropped silently
      send(8'h00);
      send(8'hFF);
      @(negedge clk);
      check("idle_junk_busy", busy, 0);
      check("idle_junk_err", {frame_err, err_count}, {1'b0, 8'd2});

      // Timeout after 16 idle cycles
      send(8'hA5);
      send(8'h13);
      check("to_busy", busy, 1);
      repeat (15) @(negedge clk);
      check("to_not_yet", {frame_err, busy}, 2'b01);
      @(negedge clk);
      check("to_err", frame_err, 1);
      check("to_code", err_code, 2);
      check("to_busy_low", busy, 0);
      check("to_count", err_count, 3);

      // Byte in the expiry cycle suppresses the timeout
      send(8'hA5);
      send(8'h13);
      repeat (15) @(negedge clk);
      send(8'h12);
      check("to_suppress", {frame_err, busy}, 2'b01);
      send(8'h34);
      send(8'h35);
      check("to_suppress_wr", {reg_wr_en, reg_addr, reg_wdata}, {1'b1, 4'h3, 16'h1234});
      check("to_suppress_count", err_count, 3);

      // Reset mid-frame
      send(8'hA5);
      send(8'h13);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out", {reg_wr_en, reg_addr, reg_wdata, err_code, err_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(8'h13, 8'h12, 8'h34, 8'h35);
      check("post_rst_wr", {reg_wr_en, reg_addr, reg_wdata}, {1'b1, 4'h3, 16'h1234});
      check("post_rst_no_err", {frame_err, err_count}, 0);

      // Saturation after 300 bad-checksum frames
      for (int i = 0; i < 300; i++) send_frame(8'h13, 8'h12, 8'h34, 8'h00);
      check("sat_count", err_count, 8'd255);
      check("sat_code", err_code, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000: maximum clk cycles allowed between consecutive bytes of one frame.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_byte  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_byte is valid in the same cycle.
REQ-007 reg_wr_en  output  1  one-cycle register-write strobe.
REQ-008 reg_addr  output  4  register address; held stable until the next write.
REQ-009 reg_wdata  output  16  register write data; held stable until the next write.
REQ-010 corr_start  output  1  one-cycle pulse that starts correlator integration.
REQ-011 corr_stop  output  1  one-cycle pulse that stops correlator integration.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 frame_err  output  1  one-cycle error pulse.
REQ-014 err_code  output  2  cause of the last error: 1 = checksum, 2 = timeout, 3 = bad opcode; held until the next error.
REQ-015 err_count  output  8  count of errors, saturating at 255.

Function
REQ-016 The frame SHALL be, in order: SYNC_BYTE, CMD, DHI, DLO, CSUM.
- CMD[7:4] = opcode; CMD[3:0] = address.
- CSUM = CMD ^ DHI ^ DLO.
REQ-017 The FSM SHALL have states IDLE, CMD, DHI, DLO, CSUM; each transition occurs only on a cycle with rx_valid=1.
- IDLE: byte == SYNC_BYTE -> CMD; any other byte is discarded with no error.
- CMD, DHI, DLO: capture the byte, then advance to the next state.
- CSUM: always returns to IDLE.
REQ-018 In CSUM, a byte matching the computed checksum SHALL execute the opcode on the following cycle, giving 1-cycle latency from the final rx_valid.
- 0x1: reg_wr_en=1, reg_addr=CMD[3:0], reg_wdata={DHI,DLO}.
- 0x2: corr_start=1; data bytes ignored.
- 0x3: corr_stop=1; data bytes ignored.
REQ-019 A checksum mismatch SHALL pulse frame_err with err_code=1 and produce no command output.
REQ-020 An opcode outside {0x1, 0x2, 0x3} with a valid checksum SHALL pulse frame_err with err_code=3 and produce no command output.
REQ-021 An inter-byte counter SHALL clear on every accepted byte and increment each cycle while not in IDLE with rx_valid=0.
- When the counter reaches TIMEOUT_CYC: pulse frame_err, set err_code=2, return to IDLE.
REQ-022 If rx_valid is high in the cycle the timeout would fire, the byte SHALL be accepted and the timeout suppressed.
REQ-023 A SYNC_BYTE value received in CMD, DHI, DLO or CSUM SHALL be treated as ordinary data; the frame does not resynchronise.
REQ-024 err_count SHALL increment by 1 on each frame_err pulse and hold at 255.
REQ-025 At most one of reg_wr_en, corr_start, corr_stop, frame_err SHALL be high in any cycle.

Reset
REQ-026 With rst_n low, the block SHALL immediately reach the following values:
- State: IDLE.
- Timer: 0.
- reg_wr_en, corr_start, corr_stop, frame_err, busy: 0.
- reg_addr: 0; reg_wdata: 0; err_code: 0; err_count: 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no command output and no error.

Structure
REQ-028 Package uart_cmd_pkg SHALL hold:
- the FSM state encoding;
- opcode constants OP_WRITE=4'h1, OP_START=4'h2, OP_STOP=4'h3;
- error codes ERR_CSUM=2'd1, ERR_TIMEOUT=2'd2, ERR_OPCODE=2'd3.
REQ-029 The inter-byte timeout counter SHALL be a sub-module, uart_cmd_timer (inputs: clear, enable; output: expired).

Verification
REQ-030 Bytes A5,13,12,34,35 -> one cycle after the last byte: reg_wr_en=1, reg_addr=3, reg_wdata=16'h1234; err_count stays 0.
REQ-031 Bytes A5,20,00,00,20 -> corr_start pulses for one cycle; reg_wr_en stays 0.
REQ-032 Bytes A5,13,12,34,00 -> frame_err=1, err_code=1, no write; a following valid frame executes normally.
REQ-033 With TIMEOUT_CYC=16: bytes A5,13, then 16 idle cycles -> frame_err=1, err_code=2, busy=0.
- Variant: a byte arriving in the expiry cycle is accepted and no error is raised.
REQ-034 Bytes A5,53,00,00,53 -> frame_err=1, err_code=3.
- 300 bad-checksum frames -> err_count=255.
REQ-035 Assert rst_n low after A5,13 -> all outputs reset; the next full frame A5,13,12,34,35 writes correctly.
